// File: rtl/lm_sm_decoder.sv
// lm_sm_decoder: consumer end of the load/store-multiple transfer path.
// Decodes the encoder's one-index-per-cycle stream into a one-hot register
// write enable, generates the matching sequential memory address, tracks
// serviced registers and pulses done when the whole list has been handled.
//
// Optional feature: define LMSM_DEC_CHECK_EN to reject out-of-list or repeated
// indices and expose a sticky err_o flag.
//
// Ports:
//   clk          clock, rising edge
//   reset        synchronous active-high reset
//   start_i      capture a new transfer (IDLE only)
//   inst_i       register list, bit i => register i transferred
//   base_i       address of the first element
//   idx_i        register index from the encoder
//   idx_en_i     idx_i valid this cycle
//   wr_onehot_o  combinational one-hot register write enable
//   addr_o       memory address of the current element
//   mask_o       registers serviced so far
//   count_o      elements accepted so far (0..8)
//   busy_o       high while ACTIVE
//   done_o       one-cycle completion pulse
//   err_o        sticky protocol error (LMSM_DEC_CHECK_EN only)
module lm_sm_decoder #(
  parameter int unsigned AW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_i,
  input  logic [7:0]    inst_i,
  input  logic [AW-1:0] base_i,
  input  logic [2:0]    idx_i,
  input  logic          idx_en_i,
  output logic [7:0]    wr_onehot_o,
  output logic [AW-1:0] addr_o,
  output logic [7:0]    mask_o,
  output logic [3:0]    count_o,
  output logic          busy_o,
  output logic          done_o
`ifdef LMSM_DEC_CHECK_EN
  ,
  output logic          err_o
`endif
);

  localparam int unsigned NREG = 8;
  localparam int unsigned CW   = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [NREG-1:0] target_q, target_d;
  logic [NREG-1:0] mask_q, mask_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [NREG-1:0] idx_onehot;
  logic            accept;
`ifdef LMSM_DEC_CHECK_EN
  logic            err_q, err_d;
`endif

  assign idx_onehot = NREG'(1) << idx_i;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      target_q <= '0;
      mask_q   <= '0;
      addr_q   <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef LMSM_DEC_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      mask_q   <= mask_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef LMSM_DEC_CHECK_EN
      err_q    <= err_d;
`endif
    end
  end

  // Next-state, datapath update and combinational write enable
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    mask_d      = mask_q;
    addr_d      = addr_q;
    count_d     = count_q;
    wr_onehot_o = '0;
    accept      = 1'b0;
`ifdef LMSM_DEC_CHECK_EN
    err_d       = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          target_d = inst_i;
          addr_d   = base_i;
          mask_d   = '0;
          count_d  = '0;
`ifdef LMSM_DEC_CHECK_EN
          err_d    = 1'b0;
`endif
          state_d  = (inst_i == '0) ? S_DONE : S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (idx_en_i) begin
`ifdef LMSM_DEC_CHECK_EN
          // Only indices in the list and not yet serviced are written
          accept = target_q[idx_i] & ~mask_q[idx_i];
          if (!accept) begin
            err_d = 1'b1;
          end
`else
          accept = 1'b1;
`endif
          if (accept) begin
            wr_onehot_o = idx_onehot;
            mask_d      = mask_q | idx_onehot;
            count_d     = count_q + CW'(1);
            addr_d      = addr_q + AW'(1);
            // Out-of-list bits are masked off so they never satisfy completion
            if (((mask_q | idx_onehot) & target_q) == target_q) begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_d = (state_d == S_ACTIVE);
  assign done_d = (state_d == S_DONE);

  assign addr_o  = addr_q;
  assign mask_o  = mask_q;
  assign count_o = count_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
`ifdef LMSM_DEC_CHECK_EN
  assign err_o   = err_q;
`endif

endmodule

// File: tb/tb_lm_sm_decoder.sv
// Self-checking bench for lm_sm_decoder: expected write/address pairs are
// queued as indices are presented and popped when wr_onehot_o fires.
module tb_lm_sm_decoder;

  localparam int unsigned AW = 16;

  logic          clk;
  logic          reset;
  logic          start_i;
  logic [7:0]    inst_i;
  logic [AW-1:0] base_i;
  logic [2:0]    idx_i;
  logic          idx_en_i;
  logic [7:0]    wr_onehot_o;
  logic [AW-1:0] addr_o;
  logic [7:0]    mask_o;
  logic [3:0]    count_o;
  logic          busy_o;
  logic          done_o;
`ifdef LMSM_DEC_CHECK_EN
  logic          err_o;
`endif

  lm_sm_decoder #(.AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start_i),
    .inst_i      (inst_i),
    .base_i      (base_i),
    .idx_i       (idx_i),
    .idx_en_i    (idx_en_i),
    .wr_onehot_o (wr_onehot_o),
    .addr_o      (addr_o),
    .mask_o      (mask_o),
    .count_o     (count_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
`ifdef LMSM_DEC_CHECK_EN
    ,
    .err_o       (err_o)
`endif
  );

  typedef struct {
    logic [7:0]    onehot;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model of the transfer in progress
  logic [7:0]    m_target;
  logic [7:0]    m_mask;
  logic [AW-1:0] m_addr;
  int            m_count;
  bit            m_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every write enable must match the next queued expectation
  always @(negedge clk) begin
    if (wr_onehot_o !== 8'h00) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got wr_onehot=%h addr=%h, none expected", wr_onehot_o, addr_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (wr_onehot_o !== e.onehot || addr_o !== e.addr) begin
          errors++;
          $display("FAIL write_pair: got wr_onehot=%h addr=%h, expected %h/%h",
                   wr_onehot_o, addr_o, e.onehot, e.addr);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] inst, input logic [AW-1:0] base);
    start_i  = 1'b1;
    inst_i   = inst;
    base_i   = base;
    idx_en_i = 1'b0;
    m_target = inst;
    m_addr   = base;
    m_mask   = 8'h00;
    m_count  = 0;
    m_err    = 1'b0;
    tick();
    start_i  = 1'b0;
  endtask

  // Present one index for one cycle; the transfer must still be running
  task automatic present(input logic [2:0] idx);
    logic [7:0] oh;
    bit         acc;
    oh = 8'h01 << idx;
`ifdef LMSM_DEC_CHECK_EN
    acc = m_target[idx] && !m_mask[idx];
`else
    acc = 1'b1;
`endif
    idx_i    = idx;
    idx_en_i = 1'b1;
    if (acc) begin
      exp_q.push_back('{onehot: oh, addr: m_addr});
      m_mask  = m_mask | oh;
      m_count = m_count + 1;
      m_addr  = m_addr + AW'(1);
    end else begin
      m_err = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b1 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL present_state: got busy=%b done=%b, expected busy=1 done=0", busy_o, done_o);
    end
    tick();
    idx_en_i = 1'b0;
  endtask

  // Expect the done pulse now, then final registered values in IDLE
  task automatic check_done(input string name, input logic [7:0] e_mask,
                            input logic [3:0] e_count, input logic [AW-1:0] e_addr);
    @(negedge clk);
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: got done=%b busy=%b, expected done=1 busy=0", name, done_o, busy_o);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_writes: %0d expected writes never seen", name, exp_q.size());
      exp_q.delete();
    end
    tick();
    @(negedge clk);
    checks++;
    if (done_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_width: got done=%b, expected 0", name, done_o);
    end
    checks++;
    if (mask_o !== e_mask || count_o !== e_count || addr_o !== e_addr) begin
      errors++;
      $display("FAIL %s_final: got mask=%h count=%0d addr=%h, expected %h/%0d/%h",
               name, mask_o, count_o, addr_o, e_mask, e_count, e_addr);
    end
    checks++;
    if (mask_o !== m_mask || count_o !== 4'(m_count) || addr_o !== m_addr) begin
      errors++;
      $display("FAIL %s_model: got mask=%h count=%0d addr=%h, model %h/%0d/%h",
               name, mask_o, count_o, addr_o, m_mask, m_count, m_addr);
    end
`ifdef LMSM_DEC_CHECK_EN
    checks++;
    if (err_o !== m_err) begin
      errors++;
      $display("FAIL %s_err: got err=%b, expected %b", name, err_o, m_err);
    end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (addr_o !== '0 || mask_o !== 8'h00 || count_o !== 4'd0) begin
      errors++;
      $display("FAIL reset_regs: got addr=%h mask=%h count=%0d, expected 0", addr_o, mask_o, count_o);
    end
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || wr_onehot_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: got busy=%b done=%b wr=%h, expected 0", busy_o, done_o, wr_onehot_o);
    end
`ifdef LMSM_DEC_CHECK_EN
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: got err=%b, expected 0", err_o);
    end
`endif
    tick();
  endtask

  task automatic test_basic();
    do_start(8'b1010_0101, 16'h0040);
    present(3'd0);
    present(3'd2);
    present(3'd5);
    present(3'd7);
    check_done("basic", 8'hA5, 4'd4, 16'h0044);
  endtask

  task automatic test_empty();
    do_start(8'h00, 16'h1234);
    check_done("empty", 8'h00, 4'd0, 16'h1234);
  endtask

  task automatic test_wrap();
    do_start(8'h07, 16'hFFFE);
    present(3'd0);
    present(3'd1);
    present(3'd2);
    check_done("wrap", 8'h07, 4'd3, 16'h0001);
  endtask

  task automatic test_gaps();
    do_start(8'h81, 16'h0010);
    present(3'd0);
    for (int i = 0; i < 3; i++) begin
      // Restart attempt while ACTIVE must be ignored
      start_i = (i == 1);
      inst_i  = 8'hFF;
      base_i  = 16'h0000;
      @(negedge clk);
      checks++;
      if (addr_o !== 16'h0011 || busy_o !== 1'b1 || count_o !== 4'd1) begin
        errors++;
        $display("FAIL gap_hold: got addr=%h busy=%b count=%0d, expected 0011/1/1", addr_o, busy_o, count_o);
      end
      tick();
    end
    start_i = 1'b0;
    present(3'd7);
    check_done("gaps", 8'h81, 4'd2, 16'h0012);
  endtask

  task automatic test_reset_mid();
    do_start(8'h0F, 16'h0100);
    present(3'd0);
    present(3'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || mask_o !== 8'h00 ||
        count_o !== 4'd0 || addr_o !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b done=%b mask=%h count=%0d addr=%h, expected all 0",
               busy_o, done_o, mask_o, count_o, addr_o);
    end
    tick();
    @(negedge clk);
    checks++;
    if (done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_nodone: got done=%b, expected 0", done_o);
    end
    tick();
  endtask

  task automatic test_dup();
    do_start(8'h03, 16'h0200);
    present(3'd0);
    present(3'd0);
    present(3'd3);
`ifdef LMSM_DEC_CHECK_EN
    @(negedge clk);
    checks++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("FAIL dup_err_set: got err=%b, expected 1", err_o);
    end
`endif
    present(3'd1);
`ifdef LMSM_DEC_CHECK_EN
    check_done("dup", 8'h03, 4'd2, 16'h0202);
`else
    check_done("dup", 8'h0B, 4'd4, 16'h0204);
`endif
  endtask

  task automatic test_back_to_back();
    do_start(8'h40, 16'h0A0A);
    present(3'd6);
    check_done("b2b_a", 8'h40, 4'd1, 16'h0A0B);
    do_start(8'h12, 16'h0000);
    present(3'd4);
    present(3'd1);
    check_done("b2b_b", 8'h12, 4'd2, 16'h0002);
  endtask

  initial begin
    reset    = 1'b1;
    start_i  = 1'b0;
    inst_i   = 8'h00;
    base_i   = '0;
    idx_i    = 3'd0;
    idx_en_i = 1'b0;
    test_reset();
    test_basic();
    test_empty();
    test_wrap();
    test_gaps();
    test_reset_mid();
    test_dup();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
